cla_multiword_add_sequencer: RTL and testbench
==============================================

// Module: cla_multiword_add_sequencer
// PURPOSE
//   Sequencer that time-shares one carry_lookahead_adder to add two wide operands.
//   Each operand is WIDTH*NUM_WORDS bits, processed one WIDTH-bit slice per cycle, LSB slice first.
//   The carry is chained between slices in a register.
//   Valid/ready handshake on both the request side and the result side; one operation in flight.
//   Carry-in uses the LSB-append trick on an adder instance of WIDTH+1 bits, so the adder needs no cin port.
// PARAMETERS
//   WIDTH      3  slice width in bits (>=1); the internal carry_lookahead_adder uses WIDTH+1
//   NUM_WORDS  4  slices per operand (>=1); operand width is WIDTH*NUM_WORDS
// PORTS
//   i_clk    in   1                    clock; all state changes on rising edge
//   i_rst_n  in   1                    synchronous active-low reset
//   i_valid  in   1                    request valid
//   o_ready  out  1                    request accept; asserted only in IDLE and when i_rst_n=1
//   i_op1    in   WIDTH*NUM_WORDS      addend 1, sampled on accept
//   i_op2    in   WIDTH*NUM_WORDS      addend 2, sampled on accept
//   o_valid  out  1                    result valid, registered
//   i_ready  in   1                    result consumer ready
//   o_sum    out  WIDTH*NUM_WORDS+1    registered sum; MSB is the final carry
// BEHAVIOUR
//   Reset
//     - i_rst_n low at an edge: state <= IDLE, o_valid <= 0, o_sum <= 0, carry <= 0, idx <= 0.
//     - o_ready = 0 while i_rst_n is low.
//     - Reset mid-operation aborts it: no o_valid is ever produced for the aborted request.
//   FSM: IDLE -> RUN -> DONE -> IDLE
//   IDLE
//     - o_ready = 1.
//     - Accept = i_valid & o_ready at an edge.
//     - On accept: capture i_op1/i_op2 into operand registers, carry <= 0, idx <= 0, state <= RUN.
//   RUN (one slice per cycle)
//     - Slices: a = op1 slice idx, b = op2 slice idx.
//     - Adder inputs: add1 = {a,1'b1}, add2 = {b,carry}; r = o_result (WIDTH+2 bits).
//     - On each edge:
//       - o_sum slice idx <= r[WIDTH:1]
//       - carry <= r[WIDTH+1]
//       - idx <= idx+1
//     - When idx == NUM_WORDS-1: o_sum[MSB] <= r[WIDTH+1], o_valid <= 1, state <= DONE.
//   DONE
//     - o_valid = 1; o_sum is held stable.
//     - i_ready = 1 at an edge: o_valid <= 0, state <= IDLE.
//     - i_ready low holds DONE indefinitely.
//   Timing
//     - Latency: o_valid rises NUM_WORDS edges after the accept edge.
//     - Minimum request-to-request spacing is NUM_WORDS+2 cycles.
//   Boundaries
//     - i_valid outside IDLE is ignored; no capture occurs, and the requester must hold its request.
//     - Operand input changes during RUN or DONE have no effect.
//     - NUM_WORDS=1: a single RUN cycle.
//     - The idx counter is $clog2(max(NUM_WORDS,2)) bits and never wraps: it resets to 0 on accept.
//     - Sum is exact: o_sum == i_op1 + i_op2 with no truncation, covering 0+0 through max+max.
//     - Partially written o_sum bits are visible during RUN but carry no meaning until o_valid.
// TESTING  (WIDTH=3, NUM_WORDS=4 unless noted; a self-checking bench compares against i_op1+i_op2)
//   1. Reset: hold i_rst_n=0 for 2 edges -> o_valid=0, o_sum=0, o_ready=0.
//      Release -> o_ready=1 in the following cycle.
//   2. 12'h005 + 12'h003 -> o_sum=13'h0008, o_valid high exactly 4 edges after accept.
//   3. Full ripple, 12'hFFF + 12'h001 -> o_sum=13'h1000.
//      Max, 12'hFFF + 12'hFFF -> 13'h1FFE.
//   4. Back-pressure: hold i_ready=0 for 10 cycles after o_valid, with i_valid=1 and new operands.
//      -> o_valid and o_sum stable, o_ready=0, no capture.
//      Then i_ready=1 -> IDLE next cycle, and the pending request is accepted.
//   5. Assert i_rst_n=0 after 2 RUN cycles -> IDLE, o_valid never asserts, o_sum=0.
//      A following 12'h123 + 12'h456 -> 13'h0579.
//   6. WIDTH=3, NUM_WORDS=1: exhaustive sweep of all 64 operand pairs.
//      -> o_sum = a+b each time, latency 1, zero errors reported.

Source files
------------

// File: rtl/cla_multiword_add_sequencer.sv
// Multi-word adder: time-shares one carry-lookahead adder over WIDTH-bit slices.
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/o_ready + i_op1/i_op2 request,
//        o_valid/i_ready + o_sum (WIDTH*NUM_WORDS+1 bits, MSB = final carry) result.

module carry_lookahead_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_add1,
   input  logic [N-1:0] i_add2,
   output logic [N:0]   o_result
);

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;
   logic         t;

   // Each carry is the OR of every generate term that survives the
   // propagate chain above it.
   always_comb begin
      g = i_add1 & i_add2;
      p = i_add1 ^ i_add2;
      c = '0;
      t = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int k = j + 1; k <= i; k++) begin
               t = t & p[k];
            end
            c[i+1] = c[i+1] | t;
         end
      end
      o_result = {c[N], p ^ c[N-1:0]};
   end

endmodule

module cla_multiword_add_sequencer #(
   parameter int WIDTH     = 3,
   parameter int NUM_WORDS = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [WIDTH*NUM_WORDS-1:0]   i_op1,
   input  logic [WIDTH*NUM_WORDS-1:0]   i_op2,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [WIDTH*NUM_WORDS:0]     o_sum
);

   localparam int OW = WIDTH * NUM_WORDS;
   localparam int IW = $clog2(NUM_WORDS > 1 ? NUM_WORDS : 2);
   localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          carry_q, carry_d;
   logic [OW-1:0] op1_q, op1_d;
   logic [OW-1:0] op2_q, op2_d;
   logic [OW:0]   sum_q, sum_d;
   logic          valid_q, valid_d;

   logic [WIDTH-1:0] slice_a;
   logic [WIDTH-1:0] slice_b;
   logic [WIDTH+1:0] r;

   assign slice_a = op1_q[int'(idx_q)*WIDTH +: WIDTH];
   assign slice_b = op2_q[int'(idx_q)*WIDTH +: WIDTH];

   // Appending 1 to one operand and carry to the other makes bit 0
   // emit the carry-in into bit 1, so the adder needs no cin port.
   carry_lookahead_adder #(.N(WIDTH + 1)) u_cla (
      .i_add1   ({slice_a, 1'b1}),
      .i_add2   ({slice_b, carry_q}),
      .o_result (r)
   );

   assign o_ready = i_rst_n && (state_q == IDLE);
   assign o_valid = valid_q;
   assign o_sum   = sum_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      sum_d   = sum_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               op1_d   = i_op1;
               op2_d   = i_op2;
               carry_d = 1'b0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[int'(idx_q)*WIDTH +: WIDTH] = r[WIDTH:1];
            carry_d = r[WIDTH+1];
            if (idx_q == LAST) begin
               sum_d[OW] = r[WIDTH+1];
               valid_d   = 1'b1;
               state_d   = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_cla_multiword_add_sequencer.sv
// Directed bench for cla_multiword_add_sequencer (4-word and 1-word builds).
// Drives requests, consumes results, and compares against hand-computed sums.

module tb_cla_multiword_add_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        v4 = 1'b0;
   logic        rdy4;
   logic [11:0] a4 = '0;
   logic [11:0] b4 = '0;
   logic        ov4;
   logic        ir4 = 1'b0;
   logic [12:0] s4;

   logic        v1 = 1'b0;
   logic        rdy1;
   logic [2:0]  a1 = '0;
   logic [2:0]  b1 = '0;
   logic        ov1;
   logic        ir1 = 1'b0;
   logic [3:0]  s1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cla_multiword_add_sequencer #(.WIDTH(3), .NUM_WORDS(4)) dut4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (v4),
      .o_ready (rdy4),
      .i_op1   (a4),
      .i_op2   (b4),
      .o_valid (ov4),
      .i_ready (ir4),
      .o_sum   (s4)
   );

   cla_multiword_add_sequencer #(.WIDTH(3), .NUM_WORDS(1)) dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (v1),
      .o_ready (rdy1),
      .i_op1   (a1),
      .i_op2   (b1),
      .o_valid (ov1),
      .i_ready (ir1),
      .o_sum   (s1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request; return sum and edges from accept to o_valid (99 on timeout).
   task automatic run4(input logic [11:0] a, input logic [11:0] b,
                       input bit consume,
                       output logic [12:0] sum, output int lat);
      bit acc;
      acc = 1'b0;
      lat = 99;
      sum = 'x;
      v4 = 1'b1;
      a4 = a;
      b4 = b;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = rdy4;
         tick();
      end
      v4 = 1'b0;
      if (acc) begin
         for (int i = 1; i <= 20; i++) begin
            tick();
            if (ov4) begin
               lat = i;
               break;
            end
         end
      end
      sum = s4;
      if (consume && lat != 99) begin
         ir4 = 1'b1;
         tick();
         ir4 = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (ov4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b want 0", ov4);
      end
      checks++;
      if (s4 !== 13'h0) begin
         errors++;
         $display("FAIL reset_sum got %h want 0000", s4);
      end
      checks++;
      if (rdy4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got %b want 0", rdy4);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (rdy4 !== 1'b1) begin
         errors++;
         $display("FAIL release_ready got %b want 1", rdy4);
      end
   endtask

   task automatic test_basic();
      logic [12:0] s;
      int lat;
      run4(12'h005, 12'h003, 1'b1, s, lat);
      checks++;
      if (s !== 13'h0008) begin
         errors++;
         $display("FAIL basic_sum got %h want 0008", s);
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL basic_latency got %0d want 4", lat);
      end
      checks++;
      if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
         errors++;
         $display("FAIL basic_release got v=%b r=%b want v=0 r=1", ov4, rdy4);
      end
      run4(12'h000, 12'h000, 1'b1, s, lat);
      checks++;
      if (s !== 13'h0000) begin
         errors++;
         $display("FAIL zero_sum got %h want 0000", s);
      end
      run4(12'hA5C, 12'h3B7, 1'b1, s, lat);
      checks++;
      if (s !== 13'h0E13) begin
         errors++;
         $display("FAIL mixed_sum got %h want 0e13", s);
      end
   endtask

   task automatic test_ripple();
      logic [12:0] s;
      int lat;
      run4(12'hFFF, 12'h001, 1'b1, s, lat);
      checks++;
      if (s !== 13'h1000) begin
         errors++;
         $display("FAIL ripple_sum got %h want 1000", s);
      end
      run4(12'hFFF, 12'hFFF, 1'b1, s, lat);
      checks++;
      if (s !== 13'h1FFE) begin
         errors++;
         $display("FAIL max_sum got %h want 1ffe", s);
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL max_latency got %0d want 4", lat);
      end
   endtask

   task automatic test_back_pressure();
      logic [12:0] s;
      int lat;
      bit bad_v;
      bit bad_s;
      bit bad_r;
      run4(12'h0F0, 12'h00F, 1'b0, s, lat);
      checks++;
      if (s !== 13'h00FF || lat != 4) begin
         errors++;
         $display("FAIL bp_first got %h lat %0d want 00ff lat 4", s, lat);
      end
      v4 = 1'b1;
      a4 = 12'h111;
      b4 = 12'h222;
      ir4 = 1'b0;
      bad_v = 1'b0;
      bad_s = 1'b0;
      bad_r = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ov4 !== 1'b1) bad_v = 1'b1;
         if (s4 !== 13'h00FF) bad_s = 1'b1;
         if (rdy4 !== 1'b0) bad_r = 1'b1;
      end
      checks++;
      if (bad_v) begin
         errors++;
         $display("FAIL bp_hold_valid got %b want 1", ov4);
      end
      checks++;
      if (bad_s) begin
         errors++;
         $display("FAIL bp_hold_sum got %h want 00ff", s4);
      end
      checks++;
      if (bad_r) begin
         errors++;
         $display("FAIL bp_hold_ready got %b want 0", rdy4);
      end
      ir4 = 1'b1;
      tick();
      ir4 = 1'b0;
      checks++;
      if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
         errors++;
         $display("FAIL bp_idle got v=%b r=%b want v=0 r=1", ov4, rdy4);
      end
      tick();
      v4 = 1'b0;
      checks++;
      if (rdy4 !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept got ready %b want 0", rdy4);
      end
      tick();
      tick();
      tick();
      checks++;
      if (ov4 !== 1'b0) begin
         errors++;
         $display("FAIL bp_early got valid %b want 0", ov4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b1 || s4 !== 13'h0333) begin
         errors++;
         $display("FAIL bp_pending got v=%b s=%h want v=1 s=0333", ov4, s4);
      end
      ir4 = 1'b1;
      tick();
      ir4 = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [12:0] s;
      int lat;
      bit seen;
      v4 = 1'b1;
      a4 = 12'hABC;
      b4 = 12'h111;
      tick();
      v4 = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (ov4 !== 1'b0 || s4 !== 13'h0 || rdy4 !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset got v=%b s=%h r=%b want 0 0000 0",
                  ov4, s4, rdy4);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ov4 !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_no_valid got valid 1 want 0");
      end
      run4(12'h123, 12'h456, 1'b1, s, lat);
      checks++;
      if (s !== 13'h0579 || lat != 4) begin
         errors++;
         $display("FAIL abort_next got %h lat %0d want 0579 lat 4", s, lat);
      end
   endtask

   task automatic test_single_word();
      logic [3:0] want;
      int lat;
      bit acc;
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) begin
            want = 4'(x + y);
            a1 = 3'(x);
            b1 = 3'(y);
            v1 = 1'b1;
            acc = 1'b0;
            for (int i = 0; i < 5 && !acc; i++) begin
               acc = rdy1;
               tick();
            end
            v1 = 1'b0;
            lat = 99;
            if (acc) begin
               for (int i = 1; i <= 5; i++) begin
                  tick();
                  if (ov1) begin
                     lat = i;
                     break;
                  end
               end
            end
            checks++;
            if (s1 !== want || lat != 1) begin
               errors++;
               $display("FAIL nw1_%0d_%0d got %h lat %0d want %h lat 1",
                        x, y, s1, lat, want);
            end
            ir1 = 1'b1;
            tick();
            ir1 = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ripple();
      test_back_pressure();
      test_reset_abort();
      test_single_word();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
